syn_acortex_pcm_buf: RTL and testbench
======================================

Name: syn_acortex_pcm_buf

Overview:
- Ping-pong PCM sample buffer in the acortex (audio) domain; hands completed sample frames to the fgyrus (FFT) block.
- The audio codec path writes samples sequentially into the fill bank.
- When a bank holds 2^ADDR_W samples, the banks swap and pcm_rdy pulses.
- fgyrus then random-reads the completed bank through pcm_rd_addr / pcm_data.

Parameters:
- ADDR_W, 7: sample index width; bank depth = 2^ADDR_W words.
- DATA_W, 32: sample word width (left/right 16-bit packed, left in [31:16]).

Ports:
- clk_ir, input, 1: system clock; all logic on rising edge.
- rst_il, input, 1: asynchronous active-low reset.
- pcm_wr_valid, input, 1: write strobe; one sample per cycle when high.
- pcm_wr_data, input, DATA_W: sample to store.
- pcm_rdy, output, 1: one-cycle pulse when a bank completes and becomes readable.
- pcm_rd_addr, input, ADDR_W: fgyrus read index into the completed bank.
- pcm_data, output, DATA_W: registered read data.
- pcm_rd_done, input, 1: fgyrus pulse indicating it has finished the current bank.
- pcm_ovf, output, 1: overflow flag (see Optional Feature).
- pcm_ovf_clr, input, 1: clears pcm_ovf.

Behaviour:
Storage and reset
- Storage is 2 banks x 2^ADDR_W x DATA_W, inferable as a single simple dual-port RAM of 2^(ADDR_W+1) words, addressed as {bank, index}.
- Reset values: wr_ptr=0, fill_bank=0, rd_bank=1, pcm_rdy=0, pcm_data=0, pcm_ovf=0, busy=0.
- RAM contents are not reset.

Write path
- On pcm_wr_valid: write pcm_wr_data to {fill_bank, wr_ptr}, then wr_ptr <= wr_ptr+1, wrapping modulo 2^ADDR_W.
- When a write lands at wr_ptr = 2^ADDR_W-1, on the same clock edge:
  - fill_bank toggles;
  - rd_bank <= old fill_bank;
  - wr_ptr wraps to 0;
  - pcm_rdy is high for exactly the next cycle;
  - busy <= 1.
- Back-to-back pcm_wr_valid every cycle is supported with no stall. The first write after a swap goes to index 0 of the new fill bank.

Read path
- pcm_data <= RAM[{rd_bank, pcm_rd_addr}] every cycle: 1-cycle latency, no read enable.
- A read of index k presented in the cycle after pcm_rdy returns the new bank's sample k one cycle later.
- Reads and writes never address the same bank simultaneously, so there are no read-during-write hazards.

Handshake and boundaries
- busy clears on pcm_rd_done.
- If pcm_rd_done and a swap occur in the same cycle, busy stays 1 (the swap wins).
- Swap while busy=1, i.e. fgyrus has not finished the previous bank: the swap still occurs, so the fill side never stalls and the older frame is lost. This is the overflow condition.
- pcm_wr_valid is ignored while rst_il=0.
- Reset mid-frame discards the partial frame; the next write goes to bank 0, index 0.

Optional Feature:
Macro SYN_PCM_BUF_OVF_EN.
- Defined:
  - pcm_ovf is set (sticky) on a swap while busy=1.
  - pcm_ovf is cleared by pcm_ovf_clr.
  - Simultaneous set and clear: set wins.
- Undefined:
  - pcm_ovf is tied 0.
  - pcm_ovf_clr is ignored.
  - Overflow logic is not synthesized.
- Swap and read behaviour is identical in both builds.

Test Plan:
- Reset, then 128 consecutive writes of data = index (0x00000000..0x0000007F), ADDR_W=7:
  - pcm_rdy pulses once, exactly 1 cycle after the 128th write;
  - reads of addr 0, 5, 127 return 0x0, 0x5, 0x7F with 1-cycle latency.
- Second frame of 128 writes of 0xA5A50000+i, with pcm_rd_done pulsed between the frames:
  - second pcm_rdy pulse;
  - addr 3 returns 0xA5A50003;
  - reads of frame 1 are stable until that swap.
- Writes with gaps (pcm_wr_valid duty 50%):
  - pcm_rdy only after the 128th valid write;
  - the write pointer does not advance on idle cycles.
- Overflow (macro defined): two full frames without pcm_rd_done:
  - pcm_ovf=1 after the second pcm_rdy;
  - pcm_ovf_clr -> 0 next cycle;
  - set and clear in the same cycle -> stays 1.
- Overflow (macro undefined): same stimulus -> pcm_ovf stays 0 throughout.
- Reset asserted after 50 writes:
  - all outputs return to 0 immediately;
  - after release, 128 writes are needed before pcm_rdy pulses.

Source files
------------

// File: rtl/syn_acortex_pcm_buf.sv
// Ping-pong PCM sample buffer: the codec fills one bank while fgyrus reads the other.
// Define SYN_PCM_BUF_OVF_EN to build the sticky overflow flag (pcm_ovf / pcm_ovf_clr).
module syn_acortex_pcm_buf #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  logic              pcm_wr_valid,
  input  logic [DATA_W-1:0] pcm_wr_data,
  output logic              pcm_rdy,
  input  logic [ADDR_W-1:0] pcm_rd_addr,
  output logic [DATA_W-1:0] pcm_data,
  input  logic              pcm_rd_done,
  output logic              pcm_ovf,
  input  logic              pcm_ovf_clr
);

  localparam int unsigned RAM_WORDS = 2 ** (ADDR_W + 1);

  logic [DATA_W-1:0] mem [0:RAM_WORDS-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic              fill_bank;
  logic              rd_bank;
  logic              busy;
  logic              swap;

  // A bank completes when the write lands on its last index.
  assign swap = pcm_wr_valid && (wr_ptr == '1);

  // Simple dual-port RAM, {bank, index}; contents are never reset.
  always_ff @(posedge clk_ir) begin
    if (pcm_wr_valid) begin
      mem[{fill_bank, wr_ptr}] <= pcm_wr_data;
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      wr_ptr    <= '0;
      fill_bank <= 1'b0;
      rd_bank   <= 1'b1;
      busy      <= 1'b0;
      pcm_rdy   <= 1'b0;
      pcm_data  <= '0;
    end else begin
      pcm_rdy  <= swap;
      pcm_data <= mem[{rd_bank, pcm_rd_addr}];
      if (pcm_wr_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (swap) begin
        fill_bank <= ~fill_bank;
        rd_bank   <= fill_bank;
      end
      // A swap re-arms busy even if fgyrus signals done in the same cycle.
      if (swap) begin
        busy <= 1'b1;
      end else if (pcm_rd_done) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef SYN_PCM_BUF_OVF_EN
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      pcm_ovf <= 1'b0;
    end else if (swap && busy) begin
      pcm_ovf <= 1'b1;
    end else if (pcm_ovf_clr) begin
      pcm_ovf <= 1'b0;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = pcm_ovf_clr ^ busy;
  assign pcm_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_syn_acortex_pcm_buf.sv
// Self-checking bench for syn_acortex_pcm_buf: randomized reads against a frame-queue reference model.
module tb_syn_acortex_pcm_buf;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic              clk_ir = 1'b0;
  logic              rst_il;
  logic              pcm_wr_valid;
  logic [DATA_W-1:0] pcm_wr_data;
  logic              pcm_rdy;
  logic [ADDR_W-1:0] pcm_rd_addr;
  logic [DATA_W-1:0] pcm_data;
  logic              pcm_rd_done;
  logic              pcm_ovf;
  logic              pcm_ovf_clr;

  syn_acortex_pcm_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_ir      (clk_ir),
    .rst_il      (rst_il),
    .pcm_wr_valid(pcm_wr_valid),
    .pcm_wr_data (pcm_wr_data),
    .pcm_rdy     (pcm_rdy),
    .pcm_rd_addr (pcm_rd_addr),
    .pcm_data    (pcm_data),
    .pcm_rd_done (pcm_rd_done),
    .pcm_ovf     (pcm_ovf),
    .pcm_ovf_clr (pcm_ovf_clr)
  );

  always #5 clk_ir = ~clk_ir;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: samples of the frame being filled, and the last completed frame.
  logic [DATA_W-1:0] fill_q[$];
  logic [DATA_W-1:0] done_q[$];
  bit                have_frame = 0;
  bit                m_pending  = 0;
  bit                m_ovf      = 0;
  bit                m_rdy      = 0;
  int unsigned       rdy_count  = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    fill_q     = {};
    done_q     = {};
    have_frame = 0;
    m_pending  = 0;
    m_ovf      = 0;
    m_rdy      = 0;
  endtask

  // Called at posedge+1; advances one clock, updates the model, checks outputs.
  task automatic tick();
    logic [DATA_W-1:0] rd_exp;
    bit                rd_known;
    bit                frame_done;
    rd_known = have_frame;
    rd_exp   = have_frame ? done_q[pcm_rd_addr] : '0;
    @(posedge clk_ir);
    frame_done = 0;
    if (pcm_wr_valid) begin
      fill_q.push_back(pcm_wr_data);
      if (fill_q.size() == DEPTH) begin
        frame_done = 1;
        done_q     = fill_q;
        fill_q     = {};
        have_frame = 1;
      end
    end
`ifdef SYN_PCM_BUF_OVF_EN
    if (frame_done && m_pending) m_ovf = 1;
    else if (pcm_ovf_clr)        m_ovf = 0;
`endif
    if (frame_done)       m_pending = 1;
    else if (pcm_rd_done) m_pending = 0;
    m_rdy = frame_done;
    if (frame_done) rdy_count++;
    #1;
    chk("pcm_rdy", {31'b0, pcm_rdy}, {31'b0, m_rdy});
    chk("pcm_ovf", {31'b0, pcm_ovf}, {31'b0, m_ovf});
    if (rd_known) chk("pcm_data", pcm_data, rd_exp);
  endtask

  task automatic cyc(input bit v, input logic [DATA_W-1:0] d);
    pcm_wr_valid = v;
    pcm_wr_data  = d;
    pcm_rd_addr  = 7'($urandom);
    tick();
  endtask

  task automatic rd_done_pulse();
    pcm_wr_valid = 0;
    pcm_rd_done  = 1;
    tick();
    pcm_rd_done  = 0;
  endtask

  task automatic read_at(input logic [ADDR_W-1:0] a, input string tag, input logic [DATA_W-1:0] exp);
    pcm_wr_valid = 0;
    pcm_rd_addr  = a;
    tick();
    chk(tag, pcm_data, exp);
  endtask

  task automatic full_frame(input logic [DATA_W-1:0] base);
    for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, base + DATA_W'(i));
    pcm_wr_valid = 0;
  endtask

  initial begin
    int unsigned n;
    int unsigned r0;
    rst_il       = 0;
    pcm_wr_valid = 0;
    pcm_wr_data  = '0;
    pcm_rd_addr  = '0;
    pcm_rd_done  = 0;
    pcm_ovf_clr  = 0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk_ir);
    #1;
    chk("rst_rdy",  {31'b0, pcm_rdy}, 32'd0);
    chk("rst_data", pcm_data, 32'd0);
    chk("rst_ovf",  {31'b0, pcm_ovf}, 32'd0);
    rst_il = 1;

    // Frame 1: data = index; pcm_rdy checked every cycle by the model.
    r0 = rdy_count;
    full_frame(32'h0000_0000);
    cyc(1'b0, '0);
    chk("f1_rdy_count", 32'(rdy_count - r0), 32'd1);
    read_at(7'd0,   "f1_addr0",   32'h0000_0000);
    read_at(7'd5,   "f1_addr5",   32'h0000_0005);
    read_at(7'd127, "f1_addr127", 32'h0000_007F);

    // Frame 2 with rd_done between frames; random reads see frame 1 until the swap.
    rd_done_pulse();
    full_frame(32'hA5A5_0000);
    read_at(7'd3,   "f2_addr3",   32'hA5A5_0003);
    read_at(7'd127, "f2_addr127", 32'hA5A5_007F);

    // Gapped writes at ~50% duty.
    rd_done_pulse();
    r0 = rdy_count;
    n  = 0;
    while (n < DEPTH) begin
      if ($urandom_range(1, 0) == 1) begin
        cyc(1'b1, $urandom);
        n++;
      end else begin
        cyc(1'b0, $urandom);
      end
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, '0);
    chk("gap_rdy_count", 32'(rdy_count - r0), 32'd1);

    // Overflow: two frames without rd_done.
    rd_done_pulse();
    full_frame(32'h1111_0000);
    cyc(1'b0, '0);
    full_frame(32'h2222_0000);
    cyc(1'b0, '0);
`ifdef SYN_PCM_BUF_OVF_EN
    chk("ovf_set", {31'b0, pcm_ovf}, 32'd1);
`else
    chk("ovf_tied", {31'b0, pcm_ovf}, 32'd0);
`endif
    pcm_ovf_clr = 1;
    cyc(1'b0, '0);
    pcm_ovf_clr = 0;
    chk("ovf_clr", {31'b0, pcm_ovf}, 32'd0);

    // Swap while busy with clear in the same cycle: set wins.
    for (int i = 0; i < int'(DEPTH) - 1; i++) cyc(1'b1, 32'h3333_0000 + DATA_W'(i));
    pcm_ovf_clr = 1;
    cyc(1'b1, 32'h3333_007F);
    pcm_ovf_clr = 0;
`ifdef SYN_PCM_BUF_OVF_EN
    chk("ovf_set_wins", {31'b0, pcm_ovf}, 32'd1);
`else
    chk("ovf_tied2", {31'b0, pcm_ovf}, 32'd0);
`endif
    read_at(7'd64, "f5_addr64", 32'h3333_0040);

    // Reset after 50 writes of a new frame.
    rd_done_pulse();
    for (int i = 0; i < 50; i++) cyc(1'b1, 32'h4444_0000 + DATA_W'(i));
    pcm_wr_valid = 1;
    #2;
    rst_il = 0;
    #1;
    chk("mid_rst_rdy",  {31'b0, pcm_rdy}, 32'd0);
    chk("mid_rst_data", pcm_data, 32'd0);
    chk("mid_rst_ovf",  {31'b0, pcm_ovf}, 32'd0);
    model_reset();
    @(posedge clk_ir);
    #1;
    pcm_wr_valid = 0;
    rst_il       = 1;

    r0 = rdy_count;
    for (int i = 0; i < int'(DEPTH) - 1; i++) cyc(1'b1, 32'h5555_0000 + DATA_W'(i));
    chk("post_rst_no_rdy", 32'(rdy_count - r0), 32'd0);
    cyc(1'b1, 32'h5555_007F);
    cyc(1'b0, '0);
    chk("post_rst_rdy_count", 32'(rdy_count - r0), 32'd1);
    read_at(7'd0,  "post_rst_addr0",  32'h5555_0000);
    read_at(7'd49, "post_rst_addr49", 32'h5555_0031);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
